// File: rtl/pcileech_com_din_arb.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_com_din_arb
// Brief    : Round-robin, packet-locked arbiter in front of the COM write
//            port, with idle-timeout recovery. Optional per-requester beat
//            counters are built when PCILEECH_COM_ARB_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module pcileech_com_din_arb #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         com_din,
    output logic                          com_din_wr_en,
    input  logic                          com_din_ready,
    output logic [NUM_REQ-1:0]            arb_grant,
    output logic                          arb_timeout,
    input  logic [2:0]                    stat_sel,
    output logic [31:0]                   stat_count
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(NUM_REQ - 1);
    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_last_grant;   // also the grantee index while in GRANT
    logic [7:0]           r_idle_cnt;

    logic                 w_found;
    logic [c_idx_w-1:0]   w_winner;
    logic [c_idx_w-1:0]   w_cand;
    logic                 w_accept;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_cand   = r_last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_idx_w'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_accept = (r_state == GRANT) && req_valid[r_last_grant] && com_din_ready;

    always_comb begin
        req_ready = '0;
        if (r_state == GRANT) begin
            req_ready = arb_grant & {NUM_REQ{com_din_ready}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= c_last_init;
            r_idle_cnt    <= '0;
            arb_grant     <= '0;
            com_din       <= '0;
            com_din_wr_en <= 1'b0;
            arb_timeout   <= 1'b0;
        end else begin
            com_din_wr_en <= 1'b0;
            arb_timeout   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_found) begin
                        r_state      <= GRANT;
                        r_last_grant <= w_winner;
                        arb_grant    <= NUM_REQ'(1) << w_winner;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        com_din       <= w_slice[r_last_grant];
                        com_din_wr_en <= 1'b1;
                        r_idle_cnt    <= '0;
                        if (req_last[r_last_grant]) begin
                            r_state   <= IDLE;
                            arb_grant <= '0;
                        end
                    end else if (req_valid[r_last_grant]) begin
                        // Backpressure from COM is not a requester stall.
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == c_timeout - 8'd1) begin
                        arb_timeout <= 1'b1;
                        arb_grant   <= '0;
                        r_idle_cnt  <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    arb_grant <= '0;
                end
            endcase
        end
    end

`ifdef PCILEECH_COM_ARB_STATS_EN
    logic [31:0] r_stat_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
            stat_count <= '0;
        end else begin
            if (w_accept) begin
                r_stat_cnt[r_last_grant] <= r_stat_cnt[r_last_grant] + 32'd1;
            end
            if ({1'b0, stat_sel} < 4'(NUM_REQ)) begin
                stat_count <= r_stat_cnt[stat_sel[c_idx_w-1:0]];
            end else begin
                stat_count <= '0;
            end
        end
    end
`else
    logic w_unused_stat;
    assign w_unused_stat = ^stat_sel;
    assign stat_count    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pcileech_com_din_arb.md
Name: pcileech_com_din_arb

Overview:
- Round-robin, packet-locked arbiter that shares the single 256-bit COM write port (com_din / com_din_wr_en / com_din_ready) of the FPGA IO bridge between several upstream producers, such as the TLP, CFG and status/loopback paths.
- Sits between pcileech_fifo-side producers and pcileech_com.
- Guarantees that multi-beat packets are never interleaved.
- Recovers from a stalled requester via an idle timeout.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 256, beat width; matches com_din.
- TIMEOUT_CYCLES, 64, consecutive cycles a granted requester may hold valid low mid-packet before the grant is revoked (1..255).

Ports:
- clk  in  1  system clock (125 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened requester beats; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_REQ  beat valid per requester.
- req_last  in  NUM_REQ  beat is last of packet.
- req_ready  out  NUM_REQ  beat accepted this cycle when valid&ready.
- com_din  out  DATA_WIDTH  registered beat to COM.
- com_din_wr_en  out  1  registered write strobe to COM.
- com_din_ready  in  1  COM can take at least 2 further beats (prog-full based).
- arb_grant  out  NUM_REQ  one-hot current grant; 0 when idle.
- arb_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.
- stat_sel  in  3  requester index for statistics readout.
- stat_count  out  32  accepted-beat count of requester stat_sel.

Behaviour:
- Reset (async, immediate): state=IDLE, arb_grant=0, req_ready=0, com_din_wr_en=0, com_din=0, arb_timeout=0, idle counter=0, last_grant pointer=NUM_REQ-1 (requester 0 wins the first arbitration), stat counters=0. Reset asserted mid-packet drops the packet; no further beats are emitted.
- States: IDLE, GRANT.
- IDLE:
  - Search req_valid starting at last_grant+1 modulo NUM_REQ; the first set bit wins.
  - If any bit is set: load one-hot arb_grant, set last_grant=winner, go to GRANT next cycle.
  - req_ready=0 in IDLE, so there is one arbitration bubble per packet.
- GRANT (grantee g):
  - req_ready[g] = com_din_ready (combinational); all other req_ready bits are 0.
  - Accept when req_valid[g] & req_ready[g]: next cycle, com_din = req_data slice g and com_din_wr_en=1 (latency 1). Otherwise com_din_wr_en=0 and com_din holds its value.
  - Accepted beat with req_last[g]=1: arb_grant=0, state→IDLE.
  - Idle counter counts cycles with req_valid[g]=0 and clears on any valid cycle. Cycles where valid=1 and com_din_ready=0 do not count (backpressure is not a stall).
  - Counter reaching TIMEOUT_CYCLES: arb_timeout=1 for one cycle, grant revoked, state→IDLE. Any later beats from g are treated as a new packet.
- Single-beat packet (valid & last in one cycle): one beat accepted, then IDLE.
- Simultaneous requests: strict rotation. With all valid and continuous single-beat packets, the grant order is 0,1,2,0,…
- A requester dropping valid while not granted has no effect.
- com_din_ready low for any duration stalls GRANT without loss.
- req_data/req_last of non-granted requesters are ignored.

Optional Feature:
- Macro PCILEECH_COM_ARB_STATS_EN.
- Defined:
  - NUM_REQ 32-bit counters, each incremented on every accepted beat of its requester, wrapping 0xFFFFFFFF→0.
  - stat_count = counter[stat_sel], registered with 1-cycle latency.
  - stat_sel ≥ NUM_REQ reads 0.
- Undefined: no counters are built; stat_count is tied to 0.

Test Plan:
- After reset, req_valid=3'b111, all req_last=1, com_din_ready=1 → arb_grant sequence 001,010,100,001; com_din_wr_en pulses with each requester's data one cycle after acceptance.
- Requester 1 sends a 4-beat packet while requester 0 is valid → 4 consecutive requester-1 beats with no requester-0 beat in between; requester 0 is granted after one bubble.
- com_din_ready low for 10 cycles mid-packet → no wr_en and no arb_timeout; data resumes intact in order.
- Granted requester 2 drops valid after beat 2 of 5 with TIMEOUT_CYCLES=64 → arb_timeout pulses on the 64th idle cycle; arb_grant=0; requester 0 is then granted.
- rst asserted during beat 3 → all outputs 0 within the same cycle; after release, requester 0 wins first.
- With PCILEECH_COM_ARB_STATS_EN, 1000 beats from requester 1 → stat_sel=1 reads 1000 and stat_sel=5 reads 0. Without the macro, stat_count=0.
